fifo_uart_tx: RTL and testbench

Read-side consumer for the on-chip synchronous FIFO. It pops words from the FIFO read port and serializes each one as an asynchronous UART frame on a single TX line. The frame is LSB-first, with optional parity and 1 or 2 stop bits. It sits between the FIFO and the chip pad, and drains whatever the write-side producer has queued.

---
 rtl/fifo_uart_tx.sv | 136 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame and sends it LSB-first with
// optional parity and one or two stop bits.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int unsigned WORD_LENGTH  = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic [WORD_LENGTH-1:0] i_fifo_data,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_read_en,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(WORD_LENGTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;
  logic                   pop;
  logic                   done;

  assign bit_end = (baud_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;
    done     = 1'b0;

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        // Gated by reset so the pop strobe stays low while reset is held.
        if (i_reset_n && i_enable && !i_fifo_empty) begin
          pop      = 1'b1;
          shift_d  = i_fifo_data;
          parity_d = (^i_fifo_data) ^ (PARITY_ODD != 0);
          baud_d   = '0;
          bit_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BitW'(WORD_LENGTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            done    = 1'b1;
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The line is registered, so it is driven from the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign o_fifo_read_en = pop;
  assign o_tx           = tx_q;
  assign o_busy         = (state_q != StIdle);
  assign o_done         = done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations fed from FIFO models, with a per-cycle
// scoreboard monitor checking every line cycle against queued expected frames.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en [NDUT];
  logic [7:0] fifo_head [NDUT];
  logic       fifo_empty [NDUT];
  logic       rd_en [NDUT];
  logic       tx [NDUT];
  logic       busy [NDUT];
  logic       done [NDUT];

  logic [7:0]  fifo_mem [NDUT][16];
  int          fifo_wr [NDUT] = '{0, 0, 0};
  int          fifo_rd [NDUT] = '{0, 0, 0};
  logic [11:0] exp_frame [NDUT][16];
  int          exp_wr [NDUT] = '{0, 0, 0};
  int          exp_rd [NDUT] = '{0, 0, 0};

  logic        active [NDUT] = '{0, 0, 0};
  int          pos [NDUT] = '{0, 0, 0};
  logic [11:0] cur [NDUT];
  logic        pend [NDUT] = '{0, 0, 0};

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // DUT 0: no parity, 1 stop. DUT 1: even parity, 1 stop. DUT 2: odd parity, 2 stop.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign fifo_head[g]  = fifo_mem[g][fifo_rd[g] % 16];
    assign fifo_empty[g] = (fifo_wr[g] == fifo_rd[g]);
    fifo_uart_tx #(
      .WORD_LENGTH (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   ((g == 0) ? 0 : 1),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 2) ? 2 : 1)
    ) u_dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_enable      (en[g]),
      .i_fifo_data   (fifo_head[g]),
      .i_fifo_empty  (fifo_empty[g]),
      .o_fifo_read_en(rd_en[g]),
      .o_tx          (tx[g]),
      .o_busy        (busy[g]),
      .o_done        (done[g])
    );
  end

  function automatic int nbits(input int d);
    return (d == 0) ? 10 : (d == 1) ? 11 : 12;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  task automatic send(input int d, input logic [7:0] w, input logic [11:0] f);
    fifo_mem[d][fifo_wr[d] % 16] = w;
    fifo_wr[d]++;
    exp_frame[d][exp_wr[d] % 16] = f;
    exp_wr[d]++;
  endtask

  // FIFO model: a pop strobe seen mid-cycle retires the head just after the edge.
  always begin
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) pend[d] = rd_en[d];
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) if (pend[d]) fifo_rd[d]++;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      int c;
      int last_c;
      logic exp_bit;
      logic have_exp;
      if (!rst_n) begin
        active[d] = 1'b0;
        check("reset_outputs", 32'({tx[d], busy[d], done[d], rd_en[d]}), 32'b1000);
      end else if (active[d]) begin
        c       = pos[d];
        last_c  = nbits(d) * CPB - 1;
        exp_bit = cur[d][c / CPB];
        check("frame_cycle", 32'({tx[d], busy[d], done[d], rd_en[d]}),
              32'({exp_bit, 1'b1, (c == last_c), 1'b0}));
        if (c == last_c) active[d] = 1'b0;
        else pos[d] = c + 1;
      end else if (rd_en[d]) begin
        have_exp = (exp_rd[d] != exp_wr[d]);
        check("pop_legal", 32'({en[d], fifo_empty[d], have_exp, tx[d], busy[d], done[d]}),
              32'b101100);
        if (have_exp) begin
          cur[d] = exp_frame[d][exp_rd[d] % 16];
          exp_rd[d]++;
        end
        active[d] = 1'b1;
        pos[d]    = 0;
      end else begin
        // The last bit flags a pop that should have happened this cycle.
        check("idle", 32'({tx[d], busy[d], done[d], en[d] & ~fifo_empty[d]}), 32'b1000);
      end
    end
  end

  task automatic wait_idle(input int d);
    logic ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(posedge clk);
      if (fifo_empty[d] && !active[d] && !busy[d]) ok = 1'b1;
    end
    check("wait_idle_in_time", 32'(ok), 32'h1);
    check("all_frames_seen", 32'(exp_wr[d] - exp_rd[d]), 32'h0);
  endtask

  task automatic wait_pos(input int d, input int p);
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (active[d] && pos[d] == p) ok = 1'b1;
    end
    check("wait_pos_in_time", 32'(ok), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) en[d] = 1'b1;
    // Reset held with a word waiting; pop must come in the first cycle after release.
    send(0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle(0);

    // Parity: even on DUT 1, odd with two stop bits on DUT 2.
    @(posedge clk); #1;
    send(1, 8'h07, 12'({1'b1, 1'b1, 8'h07, 1'b0}));
    send(1, 8'hA5, 12'({1'b1, 1'b0, 8'hA5, 1'b0}));
    send(2, 8'h07, {2'b11, 1'b0, 8'h07, 1'b0});
    send(2, 8'h80, {2'b11, 1'b0, 8'h80, 1'b0});
    send(2, 8'h00, {2'b11, 1'b1, 8'h00, 1'b0});
    wait_idle(1);
    wait_idle(2);

    // Back-to-back: monitor demands a pop on the single idle cycle between frames.
    @(posedge clk); #1;
    send(0, 8'h01, 12'({1'b1, 8'h01, 1'b0}));
    send(0, 8'h02, 12'({1'b1, 8'h02, 1'b0}));
    send(0, 8'h03, 12'({1'b1, 8'h03, 1'b0}));
    wait_idle(0);

    // Enable dropped during data bit 3 of the first frame.
    @(posedge clk); #1;
    send(0, 8'h5A, 12'({1'b1, 8'h5A, 1'b0}));
    send(0, 8'hC3, 12'({1'b1, 8'hC3, 1'b0}));
    wait_pos(0, 18);
    #1 en[0] = 1'b0;
    repeat (40) @(posedge clk);
    check("held_while_disabled", 32'({busy[0], fifo_empty[0]}), 32'b00);
    @(posedge clk); #1 en[0] = 1'b1;
    @(negedge clk);
    check("reenable_pop", 32'(rd_en[0]), 32'h1);
    wait_idle(0);

    // Asynchronous reset during a data bit of an all-zero word.
    @(posedge clk); #1;
    send(0, 8'h00, 12'({1'b1, 8'h00, 1'b0}));
    send(0, 8'h3C, 12'({1'b1, 8'h3C, 1'b0}));
    wait_pos(0, 10);
    @(negedge clk); #2;
    check("pre_reset_line_low", 32'({tx[0], busy[0]}), 32'b01);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({tx[0], busy[0], rd_en[0]}), 32'b100);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle(0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
